// File: rtl/key_debounce16_if.sv
// Key-conditioning bus: raw keys and controls in, clean encoder lines and edge pulses out.
interface key_debounce16_if;
  logic [15:0] KeyRaw;
  logic        LatchEn;
  logic        Clear;
  logic [15:0] KeyLines;
  logic [15:0] Press;
  logic [15:0] Release;
  logic        AnyKey;

  modport master (
    output KeyRaw, LatchEn, Clear,
    input  KeyLines, Press, Release, AnyKey
  );

  modport slave (
    input  KeyRaw, LatchEn, Clear,
    output KeyLines, Press, Release, AnyKey
  );
endinterface

// File: rtl/key_debounce16.sv
// 16-channel active-low key synchroniser and debouncer with optional pattern latch,
// feeding the cascaded priority encoders (KeyLines[15:8] high group, [7:0] low group).
module key_debounce16 #(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned STABLE_CNT = 10
) (
  input logic             CLK,
  input logic             RST_N,
  key_debounce16_if.slave bus
);

  localparam int unsigned NK   = 16;
  localparam int unsigned CW   = $clog2(STABLE_CNT) + 1;
  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [NK-1:0] IDLE = '1;

  logic [NK-1:0] r_sync1;
  logic [NK-1:0] r_sync2;
  logic [NK-1:0] r_deb;
  logic [NK-1:0] r_deb_prev;
  logic [NK-1:0] r_key_lines;
  logic [NK-1:0] r_press;
  logic [NK-1:0] r_release;
  logic          r_any_key;
  logic [PW-1:0] r_pre;
  logic [CW-1:0] r_cnt [NK];
  logic          w_tick;

  assign w_tick = (r_pre == PW'(TICK_DIV - 1));

  // Sample-tick prescaler
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  // Two-flop synchroniser; idle (released) is all ones
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= IDLE;
      r_sync2 <= IDLE;
    end else begin
      r_sync1 <= bus.KeyRaw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-channel stability counters; any agreeing sample restarts the count
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_deb <= IDLE;
      for (int i = 0; i < NK; i++) r_cnt[i] <= '0;
    end else if (w_tick) begin
      for (int i = 0; i < NK; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(STABLE_CNT - 1)) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Edge pulses, activity flag and encoder lines, all one cycle behind deb
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_deb_prev  <= IDLE;
      r_press     <= '0;
      r_release   <= '0;
      r_any_key   <= 1'b0;
      r_key_lines <= IDLE;
    end else begin
      r_deb_prev <= r_deb;
      r_press    <= r_deb_prev & ~r_deb;
      r_release  <= ~r_deb_prev & r_deb;
      r_any_key  <= ~&r_deb;
      if (bus.Clear) begin
        r_key_lines <= IDLE;
      end else if (!bus.LatchEn || (r_deb != IDLE)) begin
        r_key_lines <= r_deb;
      end
    end
  end

  assign bus.KeyLines = r_key_lines;
  assign bus.Press    = r_press;
  assign bus.Release  = r_release;
  assign bus.AnyKey   = r_any_key;

endmodule

// File: tb/tb_key_debounce16.sv
// Directed bench for key_debounce16: scoreboarded edge pulses plus latency and latch checks.
module tb_key_debounce16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  key_debounce16_if ifa ();
  key_debounce16_if ifb ();

  key_debounce16 #(.TICK_DIV(4), .STABLE_CNT(3)) u_dut_a (
    .CLK(clk), .RST_N(rst_n), .bus(ifa.slave)
  );
  key_debounce16 #(.TICK_DIV(1), .STABLE_CNT(1)) u_dut_b (
    .CLK(clk), .RST_N(rst_n), .bus(ifb.slave)
  );

  typedef struct packed {
    logic [15:0] press;
    logic [15:0] rel;
  } edge_t;

  edge_t       sb_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] prev_press = 16'h0;
  bit          seen_press12 = 1'b0;

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for a Press/Release bit in mask; latency counted in cycles from the call
  task automatic wait_edge(input bit on_b, input bit rel, input logic [15:0] mask,
                           input int lo, input int hi, input string tag);
    int          cnt = 0;
    bit          hit = 1'b0;
    logic [15:0] obs;
    while (!hit && cnt < 60) begin
      @(negedge clk);
      cnt++;
      obs = on_b ? (rel ? ifb.Release : ifb.Press) : (rel ? ifa.Release : ifa.Press);
      hit = ((obs & mask) != 16'h0);
    end
    n_chk++;
    assert (hit && cnt >= lo && cnt <= hi) else begin
      n_fail++;
      $error("FAIL %s: latency %0d (seen=%0d) expected %0d..%0d", tag, cnt, hit, lo, hi);
    end
  endtask

  // Scoreboard: every edge pulse on DUT A must match the next expected entry
  always @(negedge clk) begin
    edge_t e;
    if (rst_n === 1'b1 && (ifa.Press | ifa.Release) != 16'h0) begin
      if (ifa.Press[12]) seen_press12 = 1'b1;
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $error("FAIL sb_unexpected: observed press %h release %h expected none",
               ifa.Press, ifa.Release);
      end else begin
        e = sb_q.pop_front();
        check16("sb_press", ifa.Press, e.press);
        check16("sb_release", ifa.Release, e.rel);
      end
      check16("press_width", ifa.Press & prev_press, 16'h0);
    end
    prev_press = ifa.Press;
  end

  initial begin
    rst_n       = 1'b0;
    ifa.KeyRaw  = 16'hFFFF;
    ifa.LatchEn = 1'b0;
    ifa.Clear   = 1'b0;
    ifb.KeyRaw  = 16'hFFFF;
    ifb.LatchEn = 1'b0;
    ifb.Clear   = 1'b0;
    cycles(3);
    check16("rst_keylines", ifa.KeyLines, 16'hFFFF);
    check16("rst_press", ifa.Press, 16'h0);
    check16("rst_release", ifa.Release, 16'h0);
    check16("rst_anykey", {15'h0, ifa.AnyKey}, 16'h0);
    rst_n = 1'b1;

    // Reset pulse in the middle of a debounce count
    ifa.KeyRaw = 16'hFFDF;
    cycles(8);
    #2 rst_n = 1'b0;
    #1;
    check16("midrst_keylines", ifa.KeyLines, 16'hFFFF);
    check16("midrst_anykey", {15'h0, ifa.AnyKey}, 16'h0);
    check16("midrst_press", ifa.Press, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back('{press: 16'h0020, rel: 16'h0000});
    wait_edge(1'b0, 1'b0, 16'h0020, 11, 15, "press5_latency");
    check16("press5_keylines", ifa.KeyLines, 16'hFFDF);
    check16("press5_anykey", {15'h0, ifa.AnyKey}, 16'h0001);
    cycles(1);
    check16("press5_onecycle", ifa.Press, 16'h0);

    ifa.KeyRaw = 16'hFFFF;
    sb_q.push_back('{press: 16'h0000, rel: 16'h0020});
    wait_edge(1'b0, 1'b1, 16'h0020, 11, 15, "release5_latency");
    check16("release5_keylines", ifa.KeyLines, 16'hFFFF);
    check16("release5_anykey", {15'h0, ifa.AnyKey}, 16'h0);

    // Bounce on key 12: 5-cycle windows never span three ticks
    for (int s = 0; s < 8; s++) begin
      ifa.KeyRaw = (s % 2 == 0) ? 16'hEFFF : 16'hFFFF;
      cycles(5);
    end
    check16("bounce_no_press", {15'h0, seen_press12}, 16'h0);
    ifa.KeyRaw = 16'hEFFF;
    sb_q.push_back('{press: 16'h1000, rel: 16'h0000});
    wait_edge(1'b0, 1'b0, 16'h1000, 11, 15, "press12_latency");
    check16("press12_keylines", ifa.KeyLines, 16'hEFFF);
    ifa.KeyRaw = 16'hFFFF;
    sb_q.push_back('{press: 16'h0000, rel: 16'h1000});
    wait_edge(1'b0, 1'b1, 16'h1000, 11, 15, "release12_latency");

    // Latch mode holds the last pattern until Clear
    ifa.LatchEn = 1'b1;
    ifa.KeyRaw  = 16'hFFFE;
    sb_q.push_back('{press: 16'h0001, rel: 16'h0000});
    wait_edge(1'b0, 1'b0, 16'h0001, 11, 15, "press0_latency");
    check16("latch_press_keylines", ifa.KeyLines, 16'hFFFE);
    ifa.KeyRaw = 16'hFFFF;
    sb_q.push_back('{press: 16'h0000, rel: 16'h0001});
    wait_edge(1'b0, 1'b1, 16'h0001, 11, 15, "release0_latency");
    check16("latch_hold", ifa.KeyLines, 16'hFFFE);
    check16("latch_anykey", {15'h0, ifa.AnyKey}, 16'h0);
    cycles(5);
    check16("latch_hold_later", ifa.KeyLines, 16'hFFFE);
    ifa.Clear = 1'b1;
    cycles(1);
    ifa.Clear = 1'b0;
    check16("latch_clear", ifa.KeyLines, 16'hFFFF);

    // Clear coinciding with a new press wins for that cycle only
    ifa.Clear  = 1'b1;
    ifa.KeyRaw = 16'hFFF7;
    sb_q.push_back('{press: 16'h0008, rel: 16'h0000});
    wait_edge(1'b0, 1'b0, 16'h0008, 11, 15, "press3_latency");
    check16("clear_wins", ifa.KeyLines, 16'hFFFF);
    ifa.Clear = 1'b0;
    cycles(1);
    check16("after_clear", ifa.KeyLines, 16'hFFF7);
    ifa.KeyRaw = 16'hFFFF;
    sb_q.push_back('{press: 16'h0000, rel: 16'h0008});
    wait_edge(1'b0, 1'b1, 16'h0008, 11, 15, "release3_latency");
    check16("latch3_hold", ifa.KeyLines, 16'hFFF7);
    ifa.LatchEn = 1'b0;
    cycles(1);
    check16("unlatch_follow", ifa.KeyLines, 16'hFFFF);

    // Multi-key on the fast instance
    ifb.KeyRaw = 16'h7FFE;
    wait_edge(1'b1, 1'b0, 16'h8001, 4, 4, "multi_latency");
    check16("multi_press", ifb.Press, 16'h8001);
    cycles(1);
    check16("multi_keylines", ifb.KeyLines, 16'h7FFE);
    check16("multi_anykey", {15'h0, ifb.AnyKey}, 16'h0001);
    check16("multi_press_done", ifb.Press, 16'h0);

    cycles(2);
    check16("sb_drained", 16'(sb_q.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
